maze_score_poller: RTL

//  Wishbone classic initiator that periodically reads the maze counter status word {crash[7:0], timer[19:0]}.

---
 rtl/maze_score_poller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/maze_score_poller.sv
// Wishbone classic read initiator that polls the maze counter status word,
// detects a finished run (frozen nonzero timer across two reads), keeps a
// best-score record and flags bus timeouts.
module maze_score_poller #(
  parameter int          POLL_DIV   = 1000,
  parameter int          TIMEOUT    = 16,
  parameter logic [31:0] SLAVE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        enable,
  input  logic        clear_best,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic [19:0] last_timer,
  output logic [7:0]  last_crash,
  output logic [19:0] best_timer,
  output logic [7:0]  best_crash,
  output logic        best_valid,
  output logic        finished,
  output logic        new_best,
  output logic        bus_err,
  output logic [15:0] poll_count
);

  localparam int DW = $clog2(POLL_DIV + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_WAIT, S_READ, S_EVAL} state_t;

  state_t        state, state_n;
  logic [DW-1:0] div_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [19:0]   prev_timer;
  logic          cyc;
  logic          div_hit, tmo_hit, is_fin, better, fire;
  logic          unused_dat_hi;

  // Status word bits [31:28] carry nothing of interest.
  assign unused_dat_hi = ^wbm_dat_i[31:28];

  assign div_hit = (div_cnt == DW'(POLL_DIV - 1));
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  // A run is finished when the timer did not move between two good reads.
  assign is_fin = (last_timer == prev_timer) && (last_timer != 20'd0);
  assign better = !best_valid || (last_timer < best_timer) ||
                  ((last_timer == best_timer) && (last_crash < best_crash));
  assign fire   = (state == S_EVAL) && is_fin && !finished && better;

  // Bus outputs decode straight from the state register so that an async
  // reset drops cyc/stb without waiting for an edge.
  assign wbm_cyc_o = cyc;
  assign wbm_stb_o = cyc;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = cyc ? 4'hF : 4'h0;
  assign wbm_adr_o = cyc ? SLAVE_ADDR : 32'h0;
  assign wbm_dat_o = 32'h0;

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_WAIT;
    else          state <= state_n;
  end

  // Next-state and bus strobe decode; ack wins over the timeout cycle.
  always_comb begin
    state_n = state;
    cyc     = 1'b0;
    case (state)
      S_WAIT: if (enable && div_hit) state_n = S_READ;
      S_READ: begin
        cyc = 1'b1;
        if (wbm_ack_i)    state_n = S_EVAL;
        else if (tmo_hit) state_n = S_WAIT;
      end
      S_EVAL:  state_n = S_WAIT;
      default: state_n = S_WAIT;
    endcase
  end

  // Poll divider and ack timeout counters.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      div_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      if (state == S_WAIT) begin
        if (!enable || div_hit) div_cnt <= '0;
        else                    div_cnt <= div_cnt + 1'b1;
      end
      if (state == S_READ && state_n == S_READ) tmo_cnt <= tmo_cnt + 1'b1;
      else                                      tmo_cnt <= '0;
    end
  end

  // Capture of a successful read.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      last_timer <= '0;
      last_crash <= '0;
      poll_count <= '0;
    end else if (state == S_READ && wbm_ack_i) begin
      last_timer <= wbm_dat_i[19:0];
      last_crash <= wbm_dat_i[27:20];
      poll_count <= poll_count + 16'd1;
    end
  end

  // End-of-run judgement; a zero timer (slave reset) re-arms detection.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      finished   <= 1'b0;
      prev_timer <= '0;
    end else if (state == S_EVAL) begin
      finished   <= is_fin;
      prev_timer <= last_timer;
    end
  end

  // Best record and sticky bus error; clear_best beats a same-cycle update.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      best_timer <= '0;
      best_crash <= '0;
      best_valid <= 1'b0;
      new_best   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      new_best <= 1'b0;
      if (clear_best) begin
        best_timer <= '0;
        best_crash <= '0;
        best_valid <= 1'b0;
        bus_err    <= 1'b0;
      end else begin
        if (fire) begin
          best_timer <= last_timer;
          best_crash <= last_crash;
          best_valid <= 1'b1;
          new_best   <= 1'b1;
        end
        if (state == S_READ && !wbm_ack_i && tmo_hit) bus_err <= 1'b1;
      end
    end
  end

endmodule
